// File: rtl/hilo_muldiv_pkg.sv
// Shared constants for the HI/LO unit: op codes, FSM state codes and the divider
// iteration count, plus the operand magnitude helper used by the divider.
package hilo_pkg;

   localparam int unsigned DIV_CYCLES = 32;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_MULT = 3'd1;
   localparam logic [2:0] OP_MTHI = 3'd2;
   localparam logic [2:0] OP_MTLO = 3'd3;
   localparam logic [2:0] OP_DIV  = 3'd4;
   localparam logic [2:0] OP_DIVU = 3'd5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   // Sign-extend to 33 bits before negating so that |0x80000000| = 2^31 exactly.
   function automatic logic [31:0] mag32(input logic sgn, input logic [31:0] x);
      logic [32:0] ext_s;
      ext_s = {sgn & x[31], x};
      if (ext_s[32]) begin
         ext_s = 33'd0 - ext_s;
      end
      return ext_s[31:0];
   endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// Restoring shift/subtract divider datapath: {remainder, quotient} register that
// develops one quotient bit per step, MSB first, on operand magnitudes.
module div_core
   import hilo_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic        sgn,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quot,
   output logic [31:0] rem
);

   logic [63:0] acc_r;
   logic [31:0] dvs_r;
   logic [64:0] shift_s;
   logic        ge_s;
   logic [31:0] diff_s;
   logic [63:0] acc_nxt_s;

   // One restoring step; the compare is 33 bits wide since the shifted remainder can exceed 2^32-1.
   always_comb begin
      shift_s = {acc_r, 1'b0};
      ge_s    = (shift_s[64:32] >= {1'b0, dvs_r});
      diff_s  = shift_s[63:32] - dvs_r;
      if (ge_s) begin
         acc_nxt_s = {diff_s, shift_s[31:1], 1'b1};
      end else begin
         acc_nxt_s = shift_s[63:0];
      end
   end

   // Partial remainder/quotient and divisor magnitude registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= 64'd0;
         dvs_r <= 32'd0;
      end else if (load) begin
         acc_r <= {32'd0, mag32(sgn, dividend)};
         dvs_r <= mag32(sgn, divisor);
      end else if (step) begin
         acc_r <= acc_nxt_s;
      end
   end

   assign quot = acc_r[31:0];
   assign rem  = acc_r[63:32];

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register file with MULT capture, MTHI/MTLO writes and a 34-cycle
// iterative DIV/DIVU; owns the FSM, iteration counter and sign correction.
module hilo_muldiv
   import hilo_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [63:0] mult,
   input  logic [31:0] wdata,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        div_done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [4:0] CNT_LAST = 5'(DIV_CYCLES - 1);

   logic [1:0]  state_r;
   logic [4:0]  cnt_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;
   logic        div_done_r;
   logic        sgn_r;
   logic        dvd_neg_r;
   logic        dvs_neg_r;
   logic        dvz_r;
   logic [31:0] dvd_raw_r;
   logic        accept_s;
   logic        load_s;
   logic        step_s;
   logic [31:0] quot_s;
   logic [31:0] rem_s;
   logic [31:0] q_fix_s;
   logic [31:0] r_fix_s;

   assign accept_s = op_valid && (state_r == ST_IDLE);
   assign load_s   = accept_s && ((op == OP_DIV) || (op == OP_DIVU));
   assign step_s   = (state_r == ST_RUN);

   div_core u_div_core (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .step     (step_s),
      .sgn      (op == OP_DIV),
      .dividend (dividend),
      .divisor  (divisor),
      .quot     (quot_s),
      .rem      (rem_s)
   );

   // Final result: divide-by-zero bypass, else signed correction of the magnitudes.
   always_comb begin
      q_fix_s = quot_s;
      r_fix_s = rem_s;
      if (dvz_r) begin
         q_fix_s = 32'hFFFF_FFFF;
         r_fix_s = dvd_raw_r;
      end else begin
         if (sgn_r && (dvd_neg_r ^ dvs_neg_r)) begin
            q_fix_s = 32'd0 - quot_s;
         end else begin
            q_fix_s = quot_s;
         end
         if (sgn_r && dvd_neg_r) begin
            r_fix_s = 32'd0 - rem_s;
         end else begin
            r_fix_s = rem_s;
         end
      end
   end

   // Divide sequencing FSM, iteration counter and latched operand attributes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 5'd0;
         div_done_r <= 1'b0;
         sgn_r      <= 1'b0;
         dvd_neg_r  <= 1'b0;
         dvs_neg_r  <= 1'b0;
         dvz_r      <= 1'b0;
         dvd_raw_r  <= 32'd0;
      end else begin
         div_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (load_s) begin
                  state_r   <= ST_RUN;
                  cnt_r     <= 5'd0;
                  sgn_r     <= (op == OP_DIV);
                  dvd_neg_r <= (op == OP_DIV) && dividend[31];
                  dvs_neg_r <= (op == OP_DIV) && divisor[31];
                  dvz_r     <= (divisor == 32'd0);
                  dvd_raw_r <= dividend;
               end
            end
            ST_RUN: begin
               cnt_r <= cnt_r + 5'd1;
               if (cnt_r == CNT_LAST) begin
                  state_r <= ST_FIX;
               end
            end
            ST_FIX: begin
               state_r    <= ST_IDLE;
               div_done_r <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // HI/LO writes: divide result in FIX, otherwise single-cycle ops accepted in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r <= 32'd0;
         lo_r <= 32'd0;
      end else if (state_r == ST_FIX) begin
         hi_r <= r_fix_s;
         lo_r <= q_fix_s;
      end else if (accept_s) begin
         case (op)
            OP_MULT: begin
               hi_r <= mult[63:32];
               lo_r <= mult[31:0];
            end
            OP_MTHI: hi_r <= wdata;
            OP_MTLO: lo_r <= wdata;
            default: begin
            end
         endcase
      end
   end

   assign busy     = (state_r != ST_IDLE);
   assign div_done = div_done_r;
   assign hi       = hi_r;
   assign lo       = lo_r;

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

HI/LO register file and iterative divider for the MIPS pipeline. It sits directly downstream of the EX-stage ALU and captures the ALU's 64-bit signed `mult` product into HI/LO. It also executes MTHI/MTLO writes and runs DIV/DIVU as a 34-cycle multi-cycle operation, during which it raises `busy` so the hazard unit stalls the pipe. The `hi` and `lo` outputs feed the MFHI/MFLO forwarding mux.

## Interface
- `DIV_CYCLES`, 32: iteration count of the divider core. Fixed at 32 for a 32-bit datapath; no other value is supported.

- `clk` in 1: the single clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `op_valid` in 1: `op` is valid this cycle.
- `op` in 3: operation code: NOP, MULT, MTHI, MTLO, DIV, DIVU.
- `mult` in 64: signed product from the ALU; meaningful when `op` is MULT.
- `wdata` in 32: rs value for MTHI/MTLO.
- `dividend` in 32: rs value for DIV/DIVU.
- `divisor` in 32: rt value for DIV/DIVU.
- `busy` out 1: a divide is in progress; the pipeline must stall.
- `div_done` out 1: one-cycle pulse when a divide result is written.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, `div_done`=0, state IDLE.
- Ops accepted only in IDLE with `op_valid`=1. While `busy`=1, all ops are ignored with no side effects; upstream holds the op.
- MULT: `{hi,lo}` <= `mult` at the accepting edge.
- MTHI: `hi` <= `wdata`; `lo` unchanged.
- MTLO: `lo` <= `wdata`; `hi` unchanged.
- NOP or an undefined `op`: no effect.
- DIV/DIVU: latch the operands and a signed flag, then go to RUN.
  - For DIV, the magnitudes |dividend| and |divisor| are used. Magnitudes are computed with a 33-bit extension, so |0x80000000| is correct.
- RUN: restoring division, one quotient bit per cycle, MSB first, for `DIV_CYCLES` cycles. Internal counter runs 0..31; on the count of 31, go to FIX.
- FIX: sign correction, then write HI/LO, pulse `div_done`, return to IDLE.
  - Signed: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Result: `lo` = quotient, `hi` = remainder.
- Divisor = 0, both DIV and DIVU: `lo`=0xFFFFFFFF, `hi`=the raw dividend. Latency is the same as a normal divide.
- Signed 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0 (wraps; no trap).
- States: IDLE -> RUN (divide accepted) -> FIX (count = 31) -> IDLE.

## Timing
- MULT/MTHI/MTLO: single cycle. The new value is visible on `hi`/`lo` in the cycle after the accepting edge. `busy` is never raised.
- `busy` is combinational: state != IDLE. It rises in the cycle after a divide is accepted.
- Divide latency: accept at edge E0; RUN spans E1..E32; FIX is the state during the cycle after E32.
  - `hi`/`lo` are written and `div_done`=1 at edge E33.
  - `busy` is high for exactly 33 cycles (the cycles following edges E0..E32).
  - The next op can be accepted at E34.
- During `busy`, `hi`/`lo` hold their pre-divide values.
- `rst` mid-divide: at that edge, state goes to IDLE, `hi`/`lo` go to 0, `busy`=0, and no `div_done` pulse is produced.
- `rst` asserted in the same cycle as a valid op: reset wins and the op is dropped.

## Structure
- Shared package `hilo_pkg`:
  - op encodings: NOP=0, MULT=1, MTHI=2, MTLO=3, DIV=4, DIVU=5;
  - state encoding: IDLE, RUN, FIX;
  - `DIV_CYCLES`.
- One sub-module, `div_core`: the restoring shift/subtract datapath. It holds a 64-bit partial remainder/quotient register and takes load, step and signed inputs. The top level owns the FSM, the counter, sign correction and the HI/LO registers.

## Test plan
- Reset, then MULT with `mult`=0xFFFFFFFF_FFFFFFFE -> next cycle `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE, `busy`=0.
- MTHI `wdata`=0x12345678, then MTLO `wdata`=0x9ABCDEF0 -> `hi`=0x12345678, `lo`=0x9ABCDEF0.
- DIVU 100/7 -> `busy` high for 33 cycles, `div_done` pulses, `lo`=14, `hi`=2.
- DIV -7/2 -> `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1).
- DIV by 0 with dividend 0x55 -> `lo`=0xFFFFFFFF, `hi`=0x55. A MULT issued at cycle 5 of the divide is ignored, and `hi`/`lo` hold until `div_done`.
- Start DIV 0x80000000/0xFFFFFFFF and assert `rst` at cycle 10 -> `busy`=0 and `hi`=`lo`=0 the next cycle, with no `div_done` pulse. Rerun without reset -> `lo`=0x80000000, `hi`=0.
